updown_seq_checker: RTL

//  Receive-side monitor for the bouncing up/down counter output (0..MAX..0 triangle wave).

---
 rtl/updown_chk_pkg.sv | 14 +
 rtl/sat_counter.sv | 20 ++
 rtl/updown_seq_checker.sv | 122 ++++++++++++
 3 files changed

// File: rtl/updown_chk_pkg.sv
// Shared constants for the up/down triangle-wave sequence checker.
// FSM encodings are plain constants so they can be reused by older tooling.
package updown_chk_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SEED  = 2'd1;
  localparam state_t S_TRACK = 2'd2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Counter that saturates at all-ones and never wraps.
// The clear input is synchronous.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/updown_seq_checker.sv
// Monitors a bouncing 0..MAX..0 counter: locks onto the sequence and flags
// each enabled sample that deviates from the predicted next value.
module updown_seq_checker
  import updown_chk_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = (2 ** WIDTH) - 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_en,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             locked,
  output logic             dir,
  output logic [WIDTH-1:0] expected,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] turn_count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  state_t           state, state_n;
  logic [WIDTH-1:0] last, last_n, expected_n;
  logic             dir_n, locked_n, err_n;
  logic             err_inc, turn_inc;
  logic             up_seed, down_seed, adv_dir;
  logic [WIDTH:0]   adv;

  // Returns {next dir, next expected} after accepting sample v while moving in direction d.
  function automatic logic [WIDTH:0] next_step(input logic [WIDTH-1:0] v, input logic d);
    logic [WIDTH:0] r;
    if (d == DIR_UP) begin
      if (v == MAX_V) r = {DIR_DOWN, MAX_V - WIDTH'(1)};
      else            r = {DIR_UP, v + WIDTH'(1)};
    end else begin
      if (v == '0) r = {DIR_UP, WIDTH'(1)};
      else         r = {DIR_DOWN, v - WIDTH'(1)};
    end
    return r;
  endfunction

  assign up_seed   = (last < MAX_V) && (cnt_in == last + WIDTH'(1));
  assign down_seed = (last != '0)   && (cnt_in == last - WIDTH'(1));
  assign adv_dir   = (state == S_TRACK) ? dir : (down_seed ? DIR_DOWN : DIR_UP);
  assign adv       = next_step(cnt_in, adv_dir);

  always_comb begin
    state_n    = state;
    last_n     = last;
    dir_n      = dir;
    expected_n = expected;
    locked_n   = locked;
    err_n      = 1'b0;
    err_inc    = 1'b0;
    turn_inc   = 1'b0;
    if (chk_en) begin
      case (state)
        S_IDLE: begin
          last_n  = cnt_in;
          state_n = S_SEED;
        end
        S_SEED: begin
          last_n = cnt_in;
          if (up_seed || down_seed) begin
            state_n               = S_TRACK;
            locked_n              = 1'b1;
            {dir_n, expected_n}   = adv;
          end
        end
        S_TRACK: begin
          last_n = cnt_in;
          if (cnt_in == expected) begin
            {dir_n, expected_n} = adv;
            turn_inc            = (adv[WIDTH] != dir);
          end else begin
            // Resync from the offending sample; it becomes the new seed.
            err_n    = 1'b1;
            err_inc  = 1'b1;
            locked_n = 1'b0;
            state_n  = S_SEED;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      last      <= '0;
      dir       <= DIR_UP;
      expected  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      dir       <= dir_n;
      expected  <= expected_n;
      locked    <= locked_n;
      err_pulse <= err_n;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk (clk),
    .clr (rst),
    .inc (err_inc),
    .q   (err_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_turn_cnt (
    .clk (clk),
    .clr (rst),
    .inc (turn_inc),
    .q   (turn_count)
  );

endmodule
